// File: rtl/bd_clkgen.sv
// bd_clkgen: NUM_CH programmable divided clocks from refclk with lock status.
// Define BD_CLKGEN_HOLD_EN to hold outclk/tick low until locked.
module bd_clkgen #(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 10,
  parameter int LOCK_CYC = 16
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  localparam logic [CNT_W-1:0] D_DIV  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] D_HIGH = CNT_W'(DEF_DIV / 2);
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam logic [LW-1:0] SET_LAST = LW'(LOCK_CYC - 1);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  logic [CNT_W-1:0] sh_div  [NUM_CH];
  logic [CNT_W-1:0] sh_high [NUM_CH];
  logic [CNT_W-1:0] sh_ph   [NUM_CH];
  logic [CNT_W-1:0] ac_div  [NUM_CH];
  logic [CNT_W-1:0] ac_high [NUM_CH];
  logic [CNT_W-1:0] cnt     [NUM_CH];
  logic [CNT_W-1:0] cnt_nxt [NUM_CH];
  logic [CNT_W-1:0] dv      [NUM_CH];
  logic [CNT_W-1:0] hi      [NUM_CH];
  logic [NUM_CH-1:0] out_nxt;

  logic          apply_q;
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [LW-1:0] settle;
  logic [LW-1:0] settle_nxt;

  assign locked = (state == ST_RUN);

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle;
    if (apply_q) begin
      state_nxt  = ST_SETTLE;
      settle_nxt = '0;
    end else if (state == ST_SETTLE) begin
      if (settle == SET_LAST) state_nxt = ST_RUN;
      else settle_nxt = settle + LW'(1);
    end
  end

  // On an epoch the counter starts at div-phase so phase==0 lands at E+phase.
  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (apply_q) begin
        dv[i] = sh_div[i];
        hi[i] = sh_high[i];
        if (sh_ph[i] == '0 || sh_ph[i] >= sh_div[i])
          cnt_nxt[i] = '0;
        else
          cnt_nxt[i] = sh_div[i] - sh_ph[i];
      end else begin
        dv[i] = ac_div[i];
        hi[i] = ac_high[i];
        if (dv[i] == '0 || cnt[i] == dv[i] - CNT_W'(1))
          cnt_nxt[i] = '0;
        else
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
      out_nxt[i] = (dv[i] != '0) && (cnt_nxt[i] < hi[i]);
    end
`ifdef BD_CLKGEN_HOLD_EN
    out_nxt = out_nxt & {NUM_CH{state_nxt == ST_RUN}};
`else
    out_nxt = out_nxt;
`endif
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      apply_q <= 1'b1;
      state   <= ST_SETTLE;
      settle  <= '0;
      outclk  <= '0;
      tick    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_div[i]  <= D_DIV;
        sh_high[i] <= D_HIGH;
        sh_ph[i]   <= '0;
        ac_div[i]  <= D_DIV;
        ac_high[i] <= D_HIGH;
        cnt[i]     <= '0;
      end
    end else begin
      apply_q <= cfg_apply;
      state   <= state_nxt;
      settle  <= settle_nxt;
      outclk  <= out_nxt;
      tick    <= out_nxt & ~outclk;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (apply_q) begin
          ac_div[i]  <= sh_div[i];
          ac_high[i] <= sh_high[i];
        end
        if (cfg_wr && cfg_ch == 4'(i)) begin
          sh_div[i]  <= cfg_div;
          sh_high[i] <= cfg_high;
          sh_ph[i]   <= cfg_phase;
        end
      end
    end
  end

endmodule
